// File: rtl/seq_alu.sv
// Multi-cycle integer ALU. Logic, arithmetic, shift and compare ops finish in one cycle.
// Multiply and divide run iteratively for BUS_WIDTH cycles behind a start/busy/done handshake.
module seq_alu #(
    parameter int BUS_WIDTH = 32,
    parameter int SHAMT_W   = $clog2(BUS_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           alu_op,
    input  logic [BUS_WIDTH-1:0] src_a,
    input  logic [BUS_WIDTH-1:0] src_b,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] alu_result,
    output logic                 zero
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    localparam logic [SHAMT_W-1:0] COUNT_LOAD = SHAMT_W'(BUS_WIDTH - 1);
    localparam logic [SHAMT_W-1:0] COUNT_ONE  = SHAMT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ITER = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic logic [BUS_WIDTH-1:0] single_cycle_result(
        input logic [3:0]           op,
        input logic [BUS_WIDTH-1:0] a,
        input logic [BUS_WIDTH-1:0] b
    );
        logic [SHAMT_W-1:0] shamt;
        shamt = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  single_cycle_result = a + b;
            OP_SUB:  single_cycle_result = a - b;
            OP_AND:  single_cycle_result = a & b;
            OP_OR:   single_cycle_result = a | b;
            OP_XOR:  single_cycle_result = a ^ b;
            OP_SLL:  single_cycle_result = a << shamt;
            OP_SRL:  single_cycle_result = a >> shamt;
            OP_SRA:  single_cycle_result = $unsigned($signed(a) >>> shamt);
            OP_SLT:  single_cycle_result = {{(BUS_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: single_cycle_result = {{(BUS_WIDTH-1){1'b0}}, (a < b)};
            default: single_cycle_result = {BUS_WIDTH{1'b0}};
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic [SHAMT_W-1:0]       count_q, count_d;
    logic [2*BUS_WIDTH-1:0]   acc_q, acc_d;
    logic [BUS_WIDTH-1:0]     opnd_q, opnd_d;    // multiplicand or divisor
    logic [BUS_WIDTH-1:0]     shf_q, shf_d;      // multiplier (shifts right) or dividend (shifts left)
    logic [1:0]               it_op_q, it_op_d;  // alu_op[1:0] of the iterative op in flight
    logic [BUS_WIDTH-1:0]     result_q, result_d;
    logic                     zero_q, zero_d;

    logic                     start_iter_s;
    logic                     start_div_s;
    logic                     iter_is_div_s;
    logic [BUS_WIDTH:0]       mul_sum_s;
    logic [2*BUS_WIDTH-1:0]   mul_acc_s;
    logic [BUS_WIDTH:0]       div_trial_s;
    logic                     div_ge_s;
    logic [BUS_WIDTH-1:0]     div_diff_s;
    logic [BUS_WIDTH-1:0]     div_rem_s;
    logic [2*BUS_WIDTH-1:0]   div_acc_s;
    logic [2*BUS_WIDTH-1:0]   step_acc_s;
    logic [BUS_WIDTH-1:0]     new_result_s;

    // One shift-add or restoring-divide step on the accumulator.
    always_comb begin
        start_iter_s  = (alu_op == OP_MUL) || (alu_op == OP_MULHU) ||
                        (alu_op == OP_DIVU) || (alu_op == OP_REMU);
        start_div_s   = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
        iter_is_div_s = ~it_op_q[1];

        mul_sum_s = {1'b0, acc_q[2*BUS_WIDTH-1:BUS_WIDTH]} +
                    {1'b0, (shf_q[0] ? opnd_q : {BUS_WIDTH{1'b0}})};
        mul_acc_s = {mul_sum_s, acc_q[BUS_WIDTH-1:1]};

        div_trial_s = {acc_q[2*BUS_WIDTH-1:BUS_WIDTH], shf_q[BUS_WIDTH-1]};
        div_ge_s    = (div_trial_s >= {1'b0, opnd_q});
        div_diff_s  = div_trial_s[BUS_WIDTH-1:0] - opnd_q;
        div_rem_s   = div_ge_s ? div_diff_s : div_trial_s[BUS_WIDTH-1:0];
        // Upper half carries the partial remainder, lower half collects quotient bits MSB-first.
        div_acc_s   = {div_rem_s, acc_q[BUS_WIDTH-2:0], div_ge_s};

        if (iter_is_div_s) begin
            step_acc_s = div_acc_s;
        end else begin
            step_acc_s = mul_acc_s;
        end
    end

    // Next-state, datapath load and result selection.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        shf_d        = shf_q;
        it_op_d      = it_op_q;
        result_d     = result_q;
        zero_d       = zero_q;
        new_result_s = {BUS_WIDTH{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_iter_s && start_div_s && (src_b == {BUS_WIDTH{1'b0}})) begin
                        new_result_s = alu_op[0] ? src_a : {BUS_WIDTH{1'b1}};
                        result_d     = new_result_s;
                        zero_d       = (new_result_s == {BUS_WIDTH{1'b0}});
                        state_d      = S_DONE;
                    end else if (start_iter_s) begin
                        opnd_d  = start_div_s ? src_b : src_a;
                        shf_d   = start_div_s ? src_a : src_b;
                        acc_d   = {(2*BUS_WIDTH){1'b0}};
                        count_d = COUNT_LOAD;
                        it_op_d = alu_op[1:0];
                        state_d = S_ITER;
                    end else begin
                        new_result_s = single_cycle_result(alu_op, src_a, src_b);
                        result_d     = new_result_s;
                        zero_d       = (new_result_s == {BUS_WIDTH{1'b0}});
                        state_d      = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                acc_d = step_acc_s;
                if (iter_is_div_s) begin
                    shf_d = shf_q << 1;
                end else begin
                    shf_d = shf_q >> 1;
                end
                if (count_q == {SHAMT_W{1'b0}}) begin
                    // Bit 0 of the op picks the upper half: mulhu and remu.
                    new_result_s = it_op_q[0] ? step_acc_s[2*BUS_WIDTH-1:BUS_WIDTH]
                                              : step_acc_s[BUS_WIDTH-1:0];
                    result_d     = new_result_s;
                    zero_d       = (new_result_s == {BUS_WIDTH{1'b0}});
                    state_d      = S_DONE;
                end else begin
                    count_d = count_q - COUNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= {SHAMT_W{1'b0}};
            acc_q    <= {(2*BUS_WIDTH){1'b0}};
            opnd_q   <= {BUS_WIDTH{1'b0}};
            shf_q    <= {BUS_WIDTH{1'b0}};
            it_op_q  <= 2'b00;
            result_q <= {BUS_WIDTH{1'b0}};
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            shf_q    <= shf_d;
            it_op_q  <= it_op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases from the op table plus random ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] alu_result;
    logic         zero;

    int checks;
    int failures;

    seq_alu #(.BUS_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .alu_op     (alu_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .alu_result (alu_result),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_result(input logic [3:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint unsigned prod;
        int sh;
        prod = 64'(a) * 64'(b);
        sh   = int'(b % 32'd32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $unsigned($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return prod[31:0];
            4'd11:   return prod[63:32];
            4'd12:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd10 || op == 4'd11) return W + 1;
        if ((op == 4'd12 || op == 4'd13) && b != 32'd0) return W + 1;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency/result/zero/busy and the idle cycle after.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] exp_res;
        int exp_lat;
        int lat;
        exp_res = model_result(op, a, b);
        exp_lat = model_latency(op, b);
        lat     = 0;
        @(negedge clk);
        chk({tag, ".busy_pre"}, 32'(busy), 32'd0);
        start  = 1'b1;
        alu_op = op;
        src_a  = a;
        src_b  = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= W + 4 && lat == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
            end else begin
                chk({tag, ".busy_iter"}, 32'(busy), 32'd1);
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".result"}, alu_result, exp_res);
        chk({tag, ".zero"}, 32'(zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
        chk({tag, ".busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, ".done_after"}, 32'(done), 32'd0);
        chk({tag, ".busy_after"}, 32'(busy), 32'd0);
        chk({tag, ".held"}, alu_result, exp_res);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] mul_exp;
        logic [W-1:0] seen_res;
        int n_done;
        int lat;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_op   = 4'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;

        #12;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.result", alu_result, 32'd0);
        chk("reset.zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0,  32'h0000_0005, 32'hFFFF_FFFB, "add_zero");
        run_op(4'd7,  32'h8000_0000, 32'h0000_0024, "sra");
        run_op(4'd6,  32'h8000_0000, 32'h0000_0024, "srl");
        run_op(4'd8,  32'hFFFF_FFFF, 32'h0000_0001, "slt");
        run_op(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, "sltu");
        run_op(4'd10, 32'h0001_0000, 32'h0003_0000, "mul");
        run_op(4'd11, 32'h0001_0000, 32'h0003_0000, "mulhu");
        run_op(4'd12, 32'd100, 32'd7, "divu");
        run_op(4'd13, 32'd100, 32'd7, "remu");
        run_op(4'd12, 32'd5, 32'd0, "divu_by0");
        run_op(4'd13, 32'd5, 32'd0, "remu_by0");
        run_op(4'd14, 32'h1234_5678, 32'h9ABC_DEF0, "op14");
        run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, "op15");

        // start held high through a mul with changing operands: only the first op may run
        mul_exp = model_result(4'd10, 32'hDEAD_BEEF, 32'h0000_1235);
        n_done  = 0;
        lat     = 0;
        seen_res = 32'd0;
        @(negedge clk);
        start  = 1'b1;
        alu_op = 4'd10;
        src_a  = 32'hDEAD_BEEF;
        src_b  = 32'h0000_1235;
        @(posedge clk);
        #1 alu_op = 4'd0;
        for (int c = 1; c <= W + 6; c++) begin
            @(negedge clk);
            src_a = $urandom;
            src_b = $urandom;
            if (done === 1'b1) begin
                n_done++;
                if (lat == 0) begin
                    lat      = c;
                    seen_res = alu_result;
                end else begin
                    lat = lat;
                end
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ign_start.done_count", 32'(n_done), 32'd1);
        chk("ign_start.latency", 32'(lat), 32'(W + 1));
        chk("ign_start.result", seen_res, mul_exp);
        chk("ign_start.held", alu_result, mul_exp);

        // async reset in the middle of a divide
        run_op(4'd0, 32'd1, 32'd2, "pre_rst_add");
        @(negedge clk);
        start  = 1'b1;
        alu_op = 4'd12;
        src_a  = 32'd100;
        src_b  = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        chk("mid_rst.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", 32'(busy), 32'd0);
        chk("mid_rst.done", 32'(done), 32'd0);
        chk("mid_rst.result", alu_result, 32'd0);
        chk("mid_rst.zero", 32'(zero), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < W + 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("mid_rst.no_done", 32'(n_done), 32'd0);
        run_op(4'd0, 32'h0000_1000, 32'h0000_0234, "post_rst_add");

        // random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            if ((rop == 4'd12 || rop == 4'd13) && $urandom_range(0, 4) == 0) rb = 32'd0;
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
